// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I constants, fetch state encoding and opcodes shared by fetch and decode
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_FULL = 2'd2
    } fetch_state_e;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: imem handshake, redirect and decoder-side signals of the fetch stage
interface instruction_fetch_if;
    import riscv_pkg::*;
    logic            PCNextIn;
    logic [XLEN-1:0] PCTarget;
    logic            stall;
    logic            imemReq;
    logic [XLEN-1:0] imemAddr;
    logic            imemGnt;
    logic            imemRValid;
    logic [XLEN-1:0] imemRData;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instrPC;
    logic [XLEN-1:0] instrPCPlus4;
    logic            instrValid;
    logic            misalignFault;
    modport master (
        input  PCNextIn, PCTarget, stall, imemGnt, imemRValid, imemRData,
        output imemReq, imemAddr, instr, instrPC, instrPCPlus4, instrValid, misalignFault
    );
    modport slave (
        output PCNextIn, PCTarget, stall, imemGnt, imemRValid, imemRData,
        input  imemReq, imemAddr, instr, instrPC, instrPCPlus4, instrValid, misalignFault
    );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner, single-outstanding imem reader and one-entry instruction buffer
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
    input  logic                clk,
    input  logic                rst_n,
    instruction_fetch_if.master bus
);
    localparam logic [1:0] S_REQ  = FETCH_REQ;
    localparam logic [1:0] S_WAIT = FETCH_WAIT;
    localparam logic [1:0] S_FULL = FETCH_FULL;
    localparam logic [XLEN-1:0] STEP = XLEN'(4);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
    logic [XLEN-1:0] instr_q, instr_d, instr_pc_q, instr_pc_d;
    logic            drop_q, drop_d, valid_q, valid_d, fault_q, fault_d;
    logic [XLEN-1:0] target;

    assign target            = {bus.PCTarget[XLEN-1:2], 2'b00};
    assign bus.imemReq       = rst_n && state_q == S_REQ;
    assign bus.imemAddr      = pc_q;
    assign bus.instr         = instr_q;
    assign bus.instrPC       = instr_pc_q;
    assign bus.instrPCPlus4  = instr_pc_q + STEP;
    assign bus.instrValid    = valid_q;
    assign bus.misalignFault = fault_q;

    // Next-state: a redirect overrides the normal REQ/WAIT/FULL progression and marks any granted read stale
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        drop_d     = drop_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        fault_d    = bus.PCNextIn && |bus.PCTarget[1:0];
        if (bus.PCNextIn) begin
            pc_d    = target;
            valid_d = 1'b0;
            case (state_q)
                S_REQ: begin
                    state_d = bus.imemGnt ? S_WAIT : S_REQ;
                    drop_d  = bus.imemGnt;
                end
                S_WAIT: begin
                    state_d = bus.imemRValid ? S_REQ : S_WAIT;
                    drop_d  = !bus.imemRValid;
                end
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: if (bus.imemGnt) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + STEP;
                    state_d  = S_WAIT;
                end
                S_WAIT: if (bus.imemRValid) begin
                    state_d    = drop_q ? S_REQ : S_FULL;
                    drop_d     = 1'b0;
                    valid_d    = !drop_q;
                    instr_d    = drop_q ? instr_q : bus.imemRData;
                    instr_pc_d = drop_q ? instr_pc_q : req_pc_q;
                end
                default: if (!bus.stall) begin
                    valid_d = 1'b0;
                    state_d = S_REQ;
                end
            endcase
        end
    end

    // State and buffer registers; reset abandons any in-flight request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            drop_q     <= 1'b0;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= RESET_PC;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            drop_q     <= drop_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
        end
    end
endmodule
